// File: rtl/resolution_text_writer_if.sv
// ROM read port and character RAM write port of the resolution text writer.
// master = writer side, slave = ROM/RAM side.
interface resolution_text_writer_if #(
    parameter int MODE_BITS  = 4,
    parameter int LINES      = 4,
    parameter int CHARS      = 16,
    parameter int CHAR_BITS  = 8,
    parameter int ADDR_WIDTH = 11
);
    logic [MODE_BITS-1:0]       rom_mode;
    logic [$clog2(LINES)-1:0]   rom_line;
    logic [CHARS*CHAR_BITS-1:0] rom_q;
    logic                       wr_en;
    logic                       wr_ready;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [CHAR_BITS-1:0]       wr_data;

    modport master (
        output rom_mode, rom_line, wr_en, wr_addr, wr_data,
        input  rom_q, wr_ready
    );

    modport slave (
        input  rom_mode, rom_line, wr_en, wr_addr, wr_data,
        output rom_q, wr_ready
    );
endinterface

// File: rtl/resolution_text_writer.sv
// Copies the per-mode resolution text from a registered ROM into the OSD
// character RAM, one char per accepted write, refreshing on mode change.
module resolution_text_writer #(
    parameter int MODE_BITS    = 4,
    parameter int LINES        = 4,
    parameter int CHARS        = 16,
    parameter int CHAR_BITS    = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int ROW_STRIDE   = 40,
    parameter int SKIP_BLANK   = 1,
    parameter int AUTO_REFRESH = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MODE_BITS-1:0]  mode_id,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    resolution_text_writer_if.master bus,
    output logic                  busy,
    output logic                  done
);
    localparam int LW = $clog2(LINES);
    localparam int CW = $clog2(CHARS);
    localparam int BW = CHARS * CHAR_BITS;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ROM_REQ = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [MODE_BITS-1:0]  mode_q, mode_d;
    logic                  mode_valid_q, mode_valid_d;
    logic [LW-1:0]         line_q, line_d;
    logic [CW-1:0]         col_q, col_d;
    logic [BW-1:0]         buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [MODE_BITS-1:0]  rom_mode_q, rom_mode_d;
    logic [LW-1:0]         rom_line_q, rom_line_d;
    logic                  busy_q, busy_d;

    logic [CHAR_BITS-1:0]  cur_char;
    logic                  blank;
    logic                  emit;
    logic                  mode_chg;
    logic                  trigger;
    logic                  active;

    // Char 0 of a line sits in the MSBs; the buffer shifts left per char.
    always_comb begin
        cur_char = buf_q[BW-1 -: CHAR_BITS];
        blank    = (SKIP_BLANK != 0) && (cur_char == '0);
        emit     = (state_q == S_EMIT);
        mode_chg = (AUTO_REFRESH != 0) && (mode_id != mode_q);
        trigger  = start || ((AUTO_REFRESH != 0) && (!mode_valid_q || mode_chg));
        active   = (state_q == S_ROM_REQ) || (state_q == S_LOAD) || emit;
    end

    always_comb begin
        bus.wr_en    = emit && !blank;
        bus.wr_data  = emit ? cur_char : '0;
        bus.wr_addr  = emit ? line_base_q + ADDR_WIDTH'(col_q) : '0;
        bus.rom_mode = rom_mode_q;
        bus.rom_line = rom_line_q;
        busy         = busy_q;
        done         = (state_q == S_DONE);
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        line_d       = line_q;
        col_d        = col_q;
        buf_d        = buf_q;
        base_d       = base_q;
        line_base_d  = line_base_q;
        rom_mode_d   = rom_mode_q;
        rom_line_d   = rom_line_q;
        busy_d       = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    mode_d       = mode_id;
                    mode_valid_d = 1'b1;
                    line_d       = '0;
                    col_d        = '0;
                    base_d       = base_addr;
                    line_base_d  = base_addr;
                    rom_mode_d   = mode_id;
                    rom_line_d   = '0;
                    busy_d       = 1'b1;
                    state_d      = S_ROM_REQ;
                end
            end
            // ROM address was set on entry; the read is in flight.
            S_ROM_REQ: state_d = S_LOAD;
            S_LOAD: begin
                buf_d   = bus.rom_q;
                col_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (blank || bus.wr_ready) begin
                    buf_d = buf_q << CHAR_BITS;
                    col_d = col_q + CW'(1);
                    if (col_q == CW'(CHARS - 1)) begin
                        if (line_q == LW'(LINES - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            line_d      = line_q + LW'(1);
                            rom_line_d  = line_q + LW'(1);
                            line_base_d = line_base_q + ADDR_WIDTH'(ROW_STRIDE);
                            state_d     = S_ROM_REQ;
                        end
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new mode mid-run restarts from line 0 without a done pulse.
        if (active && mode_chg) begin
            mode_d      = mode_id;
            line_d      = '0;
            col_d       = '0;
            line_base_d = base_q;
            rom_mode_d  = mode_id;
            rom_line_d  = '0;
            state_d     = S_ROM_REQ;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            mode_valid_q <= 1'b0;
            line_q       <= '0;
            col_q        <= '0;
            buf_q        <= '0;
            base_q       <= '0;
            line_base_q  <= '0;
            rom_mode_q   <= '0;
            rom_line_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            line_q       <= line_d;
            col_q        <= col_d;
            buf_q        <= buf_d;
            base_q       <= base_d;
            line_base_q  <= line_base_d;
            rom_mode_q   <= rom_mode_d;
            rom_line_q   <= rom_line_d;
            busy_q       <= busy_d;
        end
    end
endmodule
